// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu program loader: header opcodes, header field
// positions and the loader FSM state encoding.
package cpu_loader_pkg;

    // Header opcode, carried in the two most significant bits of a header word
    localparam logic [1:0] OP_LOAD_IMEM = 2'b00;
    localparam logic [1:0] OP_LOAD_DMEM = 2'b01;
    localparam logic [1:0] OP_START     = 2'b10;
    localparam logic [1:0] OP_STOP      = 2'b11;

    // Header field positions; the word count occupies [CNT_W-1:0] and the
    // reserved field runs from HDR_RSVD_HI down to CNT_W
    localparam int HDR_OP_HI   = 31;
    localparam int HDR_OP_LO   = 30;
    localparam int HDR_RSVD_HI = 29;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BASE = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_e;

    // Both LOAD opcodes have a zero MSB
    function automatic logic is_load_op(input logic [1:0] op);
        return (op[1] == 1'b0);
    endfunction

endpackage

// File: rtl/loader_csum_acc.sv
// Running checksum for one loader segment. Cleared at each LOAD header, adds
// every payload word, and flags a mismatch when the closing word C does not
// bring the sum to zero modulo 2^DATA_W.
module loader_csum_acc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              mismatch_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    // Next running sum: clear wins over accumulate
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Running sum register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // A valid segment has sum(payload) + C == 0; data_i carries C when checked
    assign mismatch_o = ((sum_q + data_i) != '0);

endmodule

// File: rtl/cpu_program_loader.sv
// Boot/host loader in front of the cpu. Parses a valid/ready word stream of
// headers, base addresses and payload words, writes payloads into instruction
// or data memory through registered write ports, and gates the cpu enable.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum word per
// segment (S_CSUM state and loader_csum_acc instance).
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [31:0]       imem_addr,
    output logic              imem_wen,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [31:0]       dmem_addr,
    output logic              dmem_wen,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cpu_enable,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e SEG_END = S_CSUM;
`else
    localparam state_e SEG_END = S_HDR;
`endif

    state_e            state_q, state_d;
    logic              s_ready_q;
    logic              sel_dmem_q, sel_dmem_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              cpu_en_q, cpu_en_d;
    logic              err_q, err_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic              imem_wen_q, imem_wen_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

    logic              xfer;
    logic              load_hdr;
    logic              rsvd_hit;
    logic [1:0]        hdr_op;
    logic [CNT_W-1:0]  hdr_cnt;

    assign xfer     = s_valid & s_ready_q;
    assign hdr_op   = s_data[HDR_OP_HI:HDR_OP_LO];
    assign hdr_cnt  = s_data[CNT_W-1:0];
    assign rsvd_hit = |s_data[HDR_RSVD_HI:CNT_W];
    assign load_hdr = xfer && (state_q == S_HDR) && is_load_op(hdr_op);

`ifdef LOADER_CHECKSUM_EN
    logic csum_bad;

    loader_csum_acc #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk        (clk),
        .arst       (arst),
        .clr_i      (load_hdr),
        .acc_i      (xfer && (state_q == S_DATA)),
        .data_i     (s_data),
        .mismatch_o (csum_bad)
    );
`endif

    // Next-state, write-port and status decode for the loader FSM
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        sel_dmem_d   = sel_dmem_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        words_d      = words_q;
        cpu_en_d     = cpu_en_q;
        err_d        = err_q;
        imem_addr_d  = imem_addr_q;
        imem_wen_d   = 1'b0;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = 1'b0;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            S_HDR: begin
                if (xfer) begin
                    case (hdr_op)
                        OP_LOAD_IMEM, OP_LOAD_DMEM: begin
                            state_d    = S_BASE;
                            sel_dmem_d = (hdr_op == OP_LOAD_DMEM);
                            remain_d   = hdr_cnt;
                            words_d    = '0;
                            cpu_en_d   = 1'b0;
                        end
                        OP_START: begin
                            if (!err_q) begin
                                cpu_en_d = 1'b1;
                            end
                        end
                        default: begin
                            cpu_en_d = 1'b0;
                            err_d    = 1'b0;
                        end
                    endcase
                    // Reserved bits flag an error but the header still executes
                    if (rsvd_hit) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_BASE: begin
                if (xfer) begin
                    addr_d  = s_data[31:0];
                    state_d = (remain_q == '0) ? SEG_END : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (sel_dmem_q) begin
                        dmem_wen_d   = 1'b1;
                        dmem_addr_d  = addr_q;
                        dmem_wdata_d = s_data;
                    end else begin
                        imem_wen_d   = 1'b1;
                        imem_addr_d  = addr_q;
                        imem_wdata_d = s_data;
                    end
                    addr_d   = addr_q + 32'(ADDR_STEP);
                    remain_d = remain_q - CNT_W'(1);
                    words_d  = (&words_q) ? words_q : words_q + CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = SEG_END;
                    end
                end
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (csum_bad) begin
                        err_d = 1'b1;
                    end
                    state_d = S_HDR;
                end
`else
                state_d = S_HDR;
`endif
            end
            default: state_d = S_HDR;
        endcase
    end

    // State and output registers; reset abandons any partial load
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_HDR;
            s_ready_q    <= 1'b0;
            sel_dmem_q   <= 1'b0;
            addr_q       <= '0;
            remain_q     <= '0;
            words_q      <= '0;
            cpu_en_q     <= 1'b0;
            err_q        <= 1'b0;
            imem_addr_q  <= '0;
            imem_wen_q   <= 1'b0;
            imem_wdata_q <= '0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            s_ready_q    <= 1'b1;
            sel_dmem_q   <= sel_dmem_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            words_q      <= words_d;
            cpu_en_q     <= cpu_en_d;
            err_q        <= err_d;
            imem_addr_q  <= imem_addr_d;
            imem_wen_q   <= imem_wen_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wen     = imem_wen_q;
    assign imem_wdata   = imem_wdata_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wen     = dmem_wen_q;
    assign dmem_wdata   = dmem_wdata_q;
    // A LOAD header halts the cpu in the very cycle it is accepted
    assign cpu_enable   = cpu_en_q & ~load_hdr;
    assign busy         = (state_q != S_HDR);
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed self-checking bench for cpu_program_loader. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
// Segment checksums are sent only when LOADER_CHECKSUM_EN is defined.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [31:0] imem_addr, dmem_addr, imem_wdata, dmem_wdata;
    logic        imem_wen, dmem_wen, cpu_enable, busy, err;
    logic [15:0] words_loaded;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] seg_sum = '0;

    cpu_program_loader dut (
        .clk          (clk),
        .arst         (arst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .imem_addr    (imem_addr),
        .imem_wen     (imem_wen),
        .imem_wdata   (imem_wdata),
        .dmem_addr    (dmem_addr),
        .dmem_wen     (dmem_wen),
        .dmem_wdata   (dmem_wdata),
        .cpu_enable   (cpu_enable),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a word on the falling edge, waiting a bounded time for s_ready
    task automatic drive(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = w;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] w);
        drive(w);
        commit();
    endtask

    task automatic payload(input logic [31:0] w);
        xfer(w);
        seg_sum = seg_sum + w;
    endtask

    task automatic end_seg();
`ifdef LOADER_CHECKSUM_EN
        xfer(32'd0 - seg_sum);
`endif
        seg_sum = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_imem_wen", {31'd0, imem_wen}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("post_rst_ready_low", {31'd0, s_ready}, 32'd0);

        // 1: three-word imem load at 0x10
        xfer(32'h0000_0003);
        check("t1_busy_hdr", {31'd0, busy}, 32'd1);
        xfer(32'h0000_0010);
        payload(32'h1111_1111);
        check("t1_wen0", {31'd0, imem_wen}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0000_0010);
        check("t1_wdata0", imem_wdata, 32'h1111_1111);
        check("t1_dmem_wen0", {31'd0, dmem_wen}, 32'd0);
        check("t1_words0", {16'd0, words_loaded}, 32'd1);
        payload(32'h2222_2222);
        check("t1_wen1", {31'd0, imem_wen}, 32'd1);
        check("t1_addr1", imem_addr, 32'h0000_0014);
        payload(32'h3333_3333);
        check("t1_wen2", {31'd0, imem_wen}, 32'd1);
        check("t1_addr2", imem_addr, 32'h0000_0018);
        check("t1_wdata2", imem_wdata, 32'h3333_3333);
        check("t1_dmem_wen2", {31'd0, dmem_wen}, 32'd0);
        check("t1_words2", {16'd0, words_loaded}, 32'd3);
        end_seg();
        idle();
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_wen_idle", {31'd0, imem_wen}, 32'd0);
        check("t1_addr_hold", imem_addr, 32'h0000_0018);
        check("t1_words_hold", {16'd0, words_loaded}, 32'd3);

        // 2: dmem load then START
        xfer(32'h4000_0001);
        check("t2_words_clr", {16'd0, words_loaded}, 32'd0);
        xfer(32'h0000_0100);
        payload(32'hDEAD_BEEF);
        check("t2_dmem_wen", {31'd0, dmem_wen}, 32'd1);
        check("t2_dmem_addr", dmem_addr, 32'h0000_0100);
        check("t2_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("t2_imem_wen", {31'd0, imem_wen}, 32'd0);
        end_seg();
        drive(32'h8000_0000);
        check("t2_en_before", {31'd0, cpu_enable}, 32'd0);
        commit();
        check("t2_en_after", {31'd0, cpu_enable}, 32'd1);

        // 3: LOAD header while running halts the cpu in the acceptance cycle
        drive(32'h0000_0001);
        check("t3_en_accept", {31'd0, cpu_enable}, 32'd0);
        commit();
        check("t3_en_after", {31'd0, cpu_enable}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        xfer(32'h0000_0040);
        payload(32'h5555_AAAA);
        check("t3_wen", {31'd0, imem_wen}, 32'd1);
        check("t3_addr", imem_addr, 32'h0000_0040);
        end_seg();

        // 4: reset mid-segment
        xfer(32'h0000_0004);
        xfer(32'h0000_0080);
        payload(32'h0000_0001);
        payload(32'h0000_0002);
        check("t4_addr_mid", imem_addr, 32'h0000_0084);
        check("t4_words_mid", {16'd0, words_loaded}, 32'd2);
        #2;
        arst = 1'b1;
        #1;
        check("t4_rst_wen", {31'd0, imem_wen}, 32'd0);
        check("t4_rst_addr", imem_addr, 32'd0);
        check("t4_rst_wdata", imem_wdata, 32'd0);
        check("t4_rst_dmem_addr", dmem_addr, 32'd0);
        check("t4_rst_words", {16'd0, words_loaded}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        seg_sum = '0;
        #1;
        check("t4_release_ready", {31'd0, s_ready}, 32'd0);
        xfer(32'h4000_0001);
        xfer(32'h0000_0200);
        payload(32'h0000_0033);
        check("t4_dmem_wen", {31'd0, dmem_wen}, 32'd1);
        check("t4_dmem_addr", dmem_addr, 32'h0000_0200);
        check("t4_dmem_wdata", dmem_wdata, 32'h0000_0033);
        check("t4_imem_wen", {31'd0, imem_wen}, 32'd0);
        end_seg();

        // 6: empty segment, then reserved bits and address wrap
        xfer(32'h0000_0000);
        check("t6_busy_hdr", {31'd0, busy}, 32'd1);
        xfer(32'hFFFF_FFFC);
        end_seg();
        check("t6_busy_end", {31'd0, busy}, 32'd0);
        check("t6_no_imem", {31'd0, imem_wen}, 32'd0);
        check("t6_no_dmem", {31'd0, dmem_wen}, 32'd0);
        check("t6_words_zero", {16'd0, words_loaded}, 32'd0);
        check("t6_err_clean", {31'd0, err}, 32'd0);
        xfer(32'h2000_0002);
        check("t6_err_rsvd", {31'd0, err}, 32'd1);
        check("t6_busy_rsvd", {31'd0, busy}, 32'd1);
        xfer(32'hFFFF_FFFC);
        payload(32'h0000_0077);
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        payload(32'h0000_0088);
        check("t6_addr_wrap", imem_addr, 32'h0000_0000);
        check("t6_wdata_wrap", imem_wdata, 32'h0000_0088);
        end_seg();
        xfer(32'h8000_0000);
        check("t6_start_ignored", {31'd0, cpu_enable}, 32'd0);
        xfer(32'hC000_0000);
        check("t6_stop_clr_err", {31'd0, err}, 32'd0);
        xfer(32'h8000_0000);
        check("t6_start_ok", {31'd0, cpu_enable}, 32'd1);
        xfer(32'hC000_0000);
        check("t6_stop", {31'd0, cpu_enable}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // 5: checksum good then bad
        xfer(32'h0000_0002);
        xfer(32'h0000_0300);
        xfer(32'h0000_0001);
        xfer(32'h0000_0002);
        check("t5_busy_csum", {31'd0, busy}, 32'd1);
        xfer(32'hFFFF_FFFD);
        check("t5_err_good", {31'd0, err}, 32'd0);
        check("t5_busy_done", {31'd0, busy}, 32'd0);
        xfer(32'h0000_0002);
        xfer(32'h0000_0300);
        xfer(32'h0000_0001);
        xfer(32'h0000_0002);
        xfer(32'h0000_0000);
        check("t5_err_bad", {31'd0, err}, 32'd1);
        xfer(32'h8000_0000);
        check("t5_start_ignored", {31'd0, cpu_enable}, 32'd0);
        xfer(32'hC000_0000);
        check("t5_stop_clr", {31'd0, err}, 32'd0);
`endif

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
